// File: rtl/param_updown_counter_pkg.sv
// ----------------------------------------------------------------------------
// param_updown_counter_pkg
// Shared constants for the up/down counter.
//   WRAP / SAT : encodings for the SATURATE parameter of param_updown_counter
//   op_e       : per-edge operation after the priority decode
// ----------------------------------------------------------------------------
package param_updown_counter_pkg;

    localparam int WRAP = 0;  // roll over at the limits
    localparam int SAT  = 1;  // hold at the limits

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } op_e;

endpackage

// File: rtl/param_updown_counter.sv
// ----------------------------------------------------------------------------
// param_updown_counter
// Modulo-(MAX_VAL+1) up/down counter with parallel load, wrap or saturate at
// the limits, one-cycle carry/borrow pulses and a sticky overflow flag.
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   reset    in   synchronous active-high reset
//   load_en  in   parallel load (values above MAX_VAL clamp to MAX_VAL)
//   inc_en   in   count up
//   dec_en   in   count down (inc_en & dec_en together = hold)
//   din      in   load value
//   ovf_clr  in   clear ovf_flag (a same-edge event wins)
//   dout     out  registered count, always 0..MAX_VAL
//   carry    out  registered pulse: increment attempted at MAX_VAL
//   borrow   out  registered pulse: decrement attempted at 0
//   at_max   out  dout == MAX_VAL (combinational)
//   at_zero  out  dout == 0 (combinational)
//   ovf_flag out  sticky, set by any carry or borrow event
// ----------------------------------------------------------------------------
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int          SATURATE = WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic             inc_en,
    input  logic             dec_en,
    input  logic [WIDTH-1:0] din,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] dout,
    output logic             carry,
    output logic             borrow,
    output logic             at_max,
    output logic             at_zero,
    output logic             ovf_flag
);

    // Parameter sanity checks, evaluated at elaboration.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("param_updown_counter: WIDTH=%0d outside 2..32", WIDTH);
    end
    if (64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("param_updown_counter: MAX_VAL=%0d does not fit in WIDTH=%0d", MAX_VAL, WIDTH);
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    op_e              op;

    // Priority decode: load beats counting; inc and dec together cancel.
    always_comb begin
        op = OP_HOLD;
        if (load_en)
            op = OP_LOAD;
        else if (inc_en && !dec_en)
            op = OP_INC;
        else if (dec_en && !inc_en)
            op = OP_DEC;
    end

    always_comb begin
        cnt_d    = cnt_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        case (op)
            OP_LOAD: cnt_d = (din > MAXV) ? MAXV : din;
            OP_INC: begin
                if (cnt_q == MAXV) begin
                    carry_d = 1'b1;
                    cnt_d   = (SATURATE == SAT) ? MAXV : '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            OP_DEC: begin
                if (cnt_q == '0) begin
                    borrow_d = 1'b1;
                    cnt_d    = (SATURATE == SAT) ? '0 : MAXV;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: cnt_d = cnt_q;
        endcase
        // Set has priority over clear so a same-edge event is never lost.
        ovf_d = (ovf_q & ~ovf_clr) | carry_d | borrow_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign dout     = cnt_q;
    assign carry    = carry_q;
    assign borrow   = borrow_q;
    assign ovf_flag = ovf_q;
    assign at_max   = (cnt_q == MAXV);
    assign at_zero  = (cnt_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_param_updown_counter
// Two decade counters (WIDTH=4, MAX_VAL=9), one wrapping and one saturating,
// share one stimulus table; an 8-bit default counter runs a full 256-count
// lap. Expected values are pushed to a queue as stimulus is driven and
// compared #1 after the following rising edge.
// ----------------------------------------------------------------------------
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       rst, ld, inc, dec, clr;
    logic [3:0] din;

    logic [3:0] dout_a, dout_b;
    logic       carry_a, borrow_a, atmax_a, atzero_a, ovf_a;
    logic       carry_b, borrow_b, atmax_b, atzero_b, ovf_b;

    logic       rst_c, inc_c;
    logic [7:0] dout_c;
    logic       carry_c, borrow_c, atmax_c, atzero_c, ovf_c;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(rst), .load_en(ld), .inc_en(inc), .dec_en(dec),
        .din(din), .ovf_clr(clr), .dout(dout_a), .carry(carry_a),
        .borrow(borrow_a), .at_max(atmax_a), .at_zero(atzero_a), .ovf_flag(ovf_a));

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u_sat (
        .clk(clk), .reset(rst), .load_en(ld), .inc_en(inc), .dec_en(dec),
        .din(din), .ovf_clr(clr), .dout(dout_b), .carry(carry_b),
        .borrow(borrow_b), .at_max(atmax_b), .at_zero(atzero_b), .ovf_flag(ovf_b));

    param_updown_counter #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset(rst_c), .load_en(1'b0), .inc_en(inc_c), .dec_en(1'b0),
        .din(8'h00), .ovf_clr(1'b0), .dout(dout_c), .carry(carry_c),
        .borrow(borrow_c), .at_max(atmax_c), .at_zero(atzero_c), .ovf_flag(ovf_c));

    typedef struct {
        logic       rst, ld, inc, dec, clr;
        logic [3:0] din;
        logic [3:0] da;  logic ca, ba, oa;   // wrap expectations
        logic [3:0] db;  logic cb, bb, ob;   // saturate expectations
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   nchk = 0;
    int   nerr = 0;

    function automatic vec_t v(logic r, logic l, logic i, logic d, logic c, logic [3:0] di,
                               logic [3:0] da, logic ca, logic ba, logic oa,
                               logic [3:0] db, logic cb, logic bb, logic ob);
        vec_t t;
        t.rst = r; t.ld = l; t.inc = i; t.dec = d; t.clr = c; t.din = di;
        t.da = da; t.ca = ca; t.ba = ba; t.oa = oa;
        t.db = db; t.cb = cb; t.bb = bb; t.ob = ob;
        return t;
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(vec_t t);
        rst = t.rst; ld = t.ld; inc = t.inc; dec = t.dec; clr = t.clr; din = t.din;
        sb.push_back(t);
    endtask

    task automatic compare(int idx);
        vec_t e;
        if (sb.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL scoreboard_empty step=%0d got=0 want=1", idx);
            return;
        end
        e = sb.pop_front();
        check("dout_wrap",   idx, 32'(dout_a),   32'(e.da));
        check("carry_wrap",  idx, 32'(carry_a),  32'(e.ca));
        check("borrow_wrap", idx, 32'(borrow_a), 32'(e.ba));
        check("ovf_wrap",    idx, 32'(ovf_a),    32'(e.oa));
        check("atmax_wrap",  idx, 32'(atmax_a),  32'(e.da == 4'd9));
        check("atzero_wrap", idx, 32'(atzero_a), 32'(e.da == 4'd0));
        check("dout_sat",    idx, 32'(dout_b),   32'(e.db));
        check("carry_sat",   idx, 32'(carry_b),  32'(e.cb));
        check("borrow_sat",  idx, 32'(borrow_b), 32'(e.bb));
        check("ovf_sat",     idx, 32'(ovf_b),    32'(e.ob));
        check("atmax_sat",   idx, 32'(atmax_b),  32'(e.db == 4'd9));
        check("atzero_sat",  idx, 32'(atzero_b), 32'(e.db == 4'd0));
    endtask

    initial begin
        rst = 1'b0; ld = 1'b0; inc = 1'b0; dec = 1'b0; clr = 1'b0; din = 4'h0;
        rst_c = 1'b0; inc_c = 1'b0;

        //             rst ld inc dec clr din    wrap: d  c  b  o     sat: d  c  b  o
        tbl.push_back(v(1, 0, 0, 0, 0, 4'h0,  4'd0, 0, 0, 0,  4'd0, 0, 0, 0));
        for (int k = 1; k <= 9; k++)
            tbl.push_back(v(0, 0, 1, 0, 0, 4'h0, 4'(k), 0, 0, 0, 4'(k), 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 4'h0,  4'd0, 1, 0, 1,  4'd9, 1, 0, 1)); // limit hit
        tbl.push_back(v(0, 0, 0, 0, 0, 4'h0,  4'd0, 0, 0, 1,  4'd9, 0, 0, 1)); // pulse ends, flag sticks
        tbl.push_back(v(1, 0, 0, 0, 0, 4'h0,  4'd0, 0, 0, 0,  4'd0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 4'h0,  4'd9, 0, 1, 1,  4'd0, 0, 1, 1)); // dec at 0
        tbl.push_back(v(0, 0, 0, 0, 1, 4'h0,  4'd9, 0, 0, 0,  4'd0, 0, 0, 0)); // ovf_clr
        tbl.push_back(v(0, 1, 0, 0, 0, 4'hC,  4'd9, 0, 0, 0,  4'd9, 0, 0, 0)); // clamp
        tbl.push_back(v(0, 1, 1, 0, 0, 4'h3,  4'd3, 0, 0, 0,  4'd3, 0, 0, 0)); // load beats inc
        tbl.push_back(v(0, 1, 0, 0, 0, 4'h9,  4'd9, 0, 0, 0,  4'd9, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 0, 4'h0,  4'd9, 0, 0, 0,  4'd9, 0, 0, 0)); // inc&dec hold
        tbl.push_back(v(1, 0, 1, 0, 0, 4'h0,  4'd0, 0, 0, 0,  4'd0, 0, 0, 0)); // reset beats inc at 9
        tbl.push_back(v(0, 1, 0, 0, 0, 4'h9,  4'd9, 0, 0, 0,  4'd9, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 4'h0,  4'd0, 1, 0, 1,  4'd9, 1, 0, 1)); // set wins over clr
        tbl.push_back(v(0, 0, 0, 1, 0, 4'h0,  4'd9, 0, 1, 1,  4'd8, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 4'h0,  4'd8, 0, 0, 1,  4'd7, 0, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 4'h0,  4'd0, 0, 0, 1,  4'd0, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 1, 1, 4'h0,  4'd0, 0, 0, 0,  4'd0, 0, 0, 0)); // hold at 0, no borrow
        tbl.push_back(v(0, 0, 1, 0, 0, 4'h0,  4'd1, 0, 0, 0,  4'd1, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 4'h5,  4'd0, 0, 0, 0,  4'd0, 0, 0, 0)); // reset beats load
        tbl.push_back(v(0, 1, 0, 0, 0, 4'hF,  4'd9, 0, 0, 0,  4'd9, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 4'h5,  4'd5, 0, 0, 0,  4'd5, 0, 0, 0));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(posedge clk);
            #1;
            compare(i);
        end

        // Reset pulse entirely between edges must not disturb the count.
        ld = 1'b0; inc = 1'b0; dec = 1'b0; clr = 1'b0; rst = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("midcycle_reset_wrap", 100, 32'(dout_a), 32'd5);
        check("midcycle_reset_sat",  100, 32'(dout_b), 32'd5);

        // 8-bit default counter: one full lap, exactly one carry.
        begin
            int carries = 0;
            int idle = 0;
            logic [7:0] q8[$];
            logic       qc[$];
            rst_c = 1'b1;
            @(posedge clk); #1;
            rst_c = 1'b0;
            check("w8_reset_dout", 200, 32'(dout_c), 32'd0);
            check("w8_reset_zero", 200, 32'(atzero_c), 32'd1);
            for (int k = 0; k < 256; k++) begin
                inc_c = 1'b1;
                q8.push_back(8'(k + 1));
                qc.push_back(k == 255);
                @(posedge clk); #1;
                if (carry_c) carries++;
                check("w8_dout",  300 + k, 32'(dout_c),  32'(q8.pop_front()));
                check("w8_carry", 300 + k, 32'(carry_c), 32'(qc.pop_front()));
                if (k == 254) check("w8_at_max", 300 + k, 32'(atmax_c), 32'd1);
            end
            inc_c = 1'b0;
            @(posedge clk); #1;
            if (carry_c) idle++;
            check("w8_carry_count", 600, 32'(carries), 32'd1);
            check("w8_carry_idle",  601, 32'(idle),    32'd0);
            check("w8_ovf",         602, 32'(ovf_c),   32'd1);
            check("w8_borrow",      603, 32'(borrow_c), 32'd0);
        end

        check("scoreboard_drained", 700, 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1: terminal count; the counter counts 0..MAX_VAL (MAX_VAL=9 gives a decade counter).
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at the limits, 1 = hold at the limits.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port load_en  input  1  parallel load request.
REQ-007 SHALL have port inc_en  input  1  count-up request.
REQ-008 SHALL have port dec_en  input  1  count-down request.
REQ-009 SHALL have port din  input  WIDTH  parallel load value.
REQ-010 SHALL have port ovf_clr  input  1  clears the ovf_flag sticky bit.
REQ-011 SHALL have port dout  output  WIDTH  registered count.
REQ-012 SHALL have port carry  output  1  registered 1-cycle pulse, up-limit event.
REQ-013 SHALL have port borrow  output  1  registered 1-cycle pulse, down-limit event.
REQ-014 SHALL have port at_max  output  1  combinational, dout == MAX_VAL.
REQ-015 SHALL have port at_zero  output  1  combinational, dout == 0.
REQ-016 SHALL have port ovf_flag  output  1  sticky flag, set on any carry or borrow event.

Function
REQ-017 SHALL evaluate the following per-edge priority: reset > load_en > (inc_en XOR dec_en) > hold.
REQ-018 SHALL, on load, set dout = din when din <= MAX_VAL and dout = MAX_VAL otherwise (clamp); a load SHALL NOT pulse carry or borrow.
REQ-019 SHALL hold the count when inc_en and dec_en are both 1; carry and borrow SHALL stay 0.
REQ-020 SHALL, on increment with dout < MAX_VAL, set dout = dout+1; arithmetic uses WIDTH bits with no intermediate overflow.
REQ-021 SHALL, on increment with dout == MAX_VAL, set dout = 0 if SATURATE=0 and hold MAX_VAL if SATURATE=1; carry=1 on the next cycle in both modes.
REQ-022 SHALL, on decrement with dout > 0, set dout = dout-1.
REQ-023 SHALL, on decrement with dout == 0, set dout = MAX_VAL if SATURATE=0 and hold 0 if SATURATE=1; borrow=1 on the next cycle in both modes.
REQ-024 SHALL assert carry and borrow for exactly one cycle per event, updated in the same edge as dout (latency 1 from request), and return them to 0 otherwise.
REQ-025 SHALL set ovf_flag on the edge that sets carry or borrow; ovf_clr SHALL clear it; a simultaneous set and clear SHALL leave ovf_flag = 1.
REQ-026 SHALL derive at_max and at_zero combinationally from dout only; for MAX_VAL=0 both are 1.
REQ-027 SHALL never let dout exceed MAX_VAL under any input sequence after reset.

Reset
REQ-028 SHALL, on a rising clk edge with reset=1, set dout=0, carry=0, borrow=0 and ovf_flag=0, regardless of all other inputs.
REQ-029 SHALL take no action on a reset assertion between clock edges; a reset during a count sequence SHALL abort it with no carry or borrow pulse.

Structure
REQ-030 SHALL place the SATURATE mode encodings (WRAP=0, SAT=1) in the shared team constants package/header.
REQ-031 SHALL be a single module with no sub-modules; the limit-compare logic is inline.
REQ-032 SHALL flag an elaboration-time error when MAX_VAL > 2**WIDTH-1 or WIDTH is outside 2..32.

Verification (WIDTH=4, MAX_VAL=9 unless stated)
REQ-033 SHALL cover: reset, then inc_en held for 10 cycles -> dout 1..9, then 0; carry=1 only in the cycle dout returns to 0; ovf_flag=1 afterwards.
REQ-034 SHALL cover: from dout=0 with dec_en=1 for 1 cycle -> dout=9 and borrow pulses 1 cycle; with SATURATE=1 the same stimulus -> dout=0 and borrow pulses.
REQ-035 SHALL cover: load_en=1 with din=4'hC -> dout=9; load_en=1, inc_en=1, din=3 -> dout=3 with no carry.
REQ-036 SHALL cover: inc_en=dec_en=1 at dout=9 -> dout holds 9, carry=0, borrow=0.
REQ-037 SHALL cover: reset=1 in the same cycle as inc_en at dout=9 -> dout=0, carry=0, ovf_flag=0; ovf_clr together with a carry event -> ovf_flag stays 1.
REQ-038 SHALL cover: WIDTH=8 with default MAX_VAL, 256 increments from 0 -> dout=0 with a single carry pulse.
